stepper_mmio: RTL
=================

STEPPER_MMIO -- requirements
Module: stepper_mmio

Interface
REQ-001 SHALL have parameter CMD_ADDR, default 12'd4000, meaning the dmem word address that enqueues a motion command.
REQ-002 SHALL have parameter STATUS_ADDR, default 12'd4001, meaning the dmem word address that clears the overflow flag when written.
REQ-003 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-004 SHALL have port clock, input, 1, the processor clock (single clock domain).
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wren, input, 1, processor data-memory write enable.
REQ-007 SHALL have port address_dmem, input, 12, processor data-memory word address.
REQ-008 SHALL have port data, input, 32, processor write data.
REQ-009 SHALL have port status_q, output, 32, registered status word.
REQ-010 SHALL have port step, output, 1, registered step pulse to the motor driver.
REQ-011 SHALL have port dir, output, 1, registered direction to the motor driver.
REQ-012 SHALL have port busy, output, 1, high while any command is queued or executing.

Function
REQ-013 SHALL decode a command as data[31] = dir, data[30:16] = step count N (15 bits), data[15:0] = half-period H in cycles; effective half-period P = (H == 0) ? 1 : H.
REQ-014 SHALL push data into the FIFO on any clock edge where wren = 1 and address_dmem = CMD_ADDR, provided the FIFO is not full or a pop occurs on the same edge.
REQ-015 SHALL drop a push to a full FIFO with no pop on that edge, leave contents unchanged, and set sticky overflow.
REQ-016 SHALL clear overflow on wren = 1 with address_dmem = STATUS_ADDR; a set and a clear on the same edge SHALL leave overflow set.
REQ-017 SHALL ignore writes to all other addresses.
REQ-018 SHALL implement FSM states IDLE, LOAD, HIGH, LOW.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry into working registers (dir, N, P) and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-020 In LOAD, the FSM SHALL drive dir from the working register; if N = 0, go to IDLE with no pulse; else go to HIGH and load timer = P.
REQ-021 In HIGH, step SHALL be 1 for exactly P cycles, then the FSM SHALL go to LOW and reload timer = P.
REQ-022 In LOW, step SHALL be 0 for exactly P cycles, then decrement N; if the new N = 0, go to IDLE, else go to HIGH.
REQ-023 step and dir SHALL be registered; dir SHALL change only on LOAD and remain stable through all pulses of that command.
REQ-024 Latency: for a write sampled on edge E0 into an empty FIFO with the FSM in IDLE, step SHALL rise after edge E0+2.
REQ-025 Back-to-back commands: after the final LOW of one command, the next queued command SHALL reach LOAD without extra idle cycles (IDLE, then LOAD).
REQ-026 busy SHALL equal (state != IDLE) OR (FIFO count != 0), combinationally from registered state.
REQ-027 status_q SHALL update every cycle to {overflow, busy, fifo_count[2:0] (saturating at 7), 12'b0, remaining N[14:0]}.
REQ-028 All arithmetic SHALL be unsigned; the timer SHALL be 16 bits; N SHALL never wrap below 0.

Reset
REQ-029 On reset = 1 at a clock edge, the block SHALL empty the FIFO, go to IDLE, and clear overflow, step, dir, status_q, N and the timer to 0.
REQ-030 Reset asserted mid-command SHALL abort the command immediately (step = 0 after that edge), and no queued command SHALL survive.
REQ-031 A write coincident with reset SHALL be discarded.

Verification
REQ-032 Write 0x8003_0002 to CMD_ADDR -> step rises 2 edges later; 3 pulses, each 2 high / 2 low; dir = 1 throughout; busy falls after the last low.
REQ-033 Write 0x0001_0000 (H = 0) -> a single pulse 1 cycle high, 1 cycle low; dir = 0.
REQ-034 Write count 0 (0x0000_0005) -> no step edge; busy high for exactly 2 cycles.
REQ-035 Six writes on consecutive cycles with DEPTH = 4 and a long first command -> 5 accepted (1 popped plus 4 queued), 1 dropped, status_q[31] = 1; a write to STATUS_ADDR clears it.
REQ-036 Reset asserted during the 2nd pulse of a 10-step command with 2 queued -> step = 0, busy = 0, and status_q = 0 on the next cycle.
REQ-037 Push on the same edge that IDLE pops from a full FIFO -> accepted, count stays DEPTH, overflow stays 0.

Source files
------------

// File: rtl/stepper_mmio.sv
// Memory-mapped stepper motor pulse generator: processor writes queue motion
// commands in a small FIFO, and a sequencer turns each one into step/dir pulses.
module stepper_mmio #(
  parameter logic [11:0] CMD_ADDR    = 12'd4000,
  parameter logic [11:0] STATUS_ADDR = 12'd4001,
  parameter int unsigned DEPTH       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] status_q,
  output logic        step,
  output logic        dir,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = 15;
  localparam int unsigned TW = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW
  } state_t;

  state_t          state;
  logic [31:0]     fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;

  logic            work_dir;
  logic [NW-1:0]   work_n;
  logic [TW-1:0]   work_p;
  logic [TW-1:0]   timer;

  logic            push_req;
  logic            clr_req;
  logic            full;
  logic            pop;
  logic            push;
  logic [31:0]     head;
  logic [2:0]      count_sat;

  // Write decode and FIFO handshake; a pop frees a slot for a same-edge push.
  always_comb begin
    push_req  = wren && (address_dmem == CMD_ADDR);
    clr_req   = wren && (address_dmem == STATUS_ADDR);
    full      = (count == CW'(DEPTH));
    pop       = (state == IDLE) && (count != '0);
    push      = push_req && (!full || pop);
    busy      = (state != IDLE) || (count != '0);
    head      = fifo_mem[rd_ptr];
    count_sat = (32'(count) > 32'd7) ? 3'd7 : 3'(count);
  end

  // FIFO storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A dropped push wins over a clear on the same edge.
      if (push_req && !push) begin
        overflow <= 1'b1;
      end else if (clr_req) begin
        overflow <= 1'b0;
      end
    end
  end

  // Command sequencer: each step is P cycles high followed by P cycles low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      step     <= 1'b0;
      dir      <= 1'b0;
      work_dir <= 1'b0;
      work_n   <= '0;
      work_p   <= '0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            work_dir <= head[31];
            work_n   <= head[30:16];
            work_p   <= (head[15:0] == 16'd0) ? 16'd1 : head[15:0];
            state    <= LOAD;
          end
        end
        LOAD: begin
          dir <= work_dir;
          if (work_n == '0) begin
            state <= IDLE;
          end else begin
            state <= HIGH;
            timer <= work_p;
            step  <= 1'b1;
          end
        end
        HIGH: begin
          if (timer <= TW'(1)) begin
            state <= LOW;
            timer <= work_p;
            step  <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        LOW: begin
          if (timer <= TW'(1)) begin
            if (work_n != '0) begin
              work_n <= work_n - NW'(1);
            end
            if (work_n <= NW'(1)) begin
              state <= IDLE;
              timer <= '0;
            end else begin
              state <= HIGH;
              timer <= work_p;
              step  <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          step  <= 1'b0;
        end
      endcase
    end
  end

  // Status snapshot of the registered state, refreshed every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_q <= '0;
    end else begin
      status_q <= {overflow, busy, count_sat, 12'd0, work_n};
    end
  end

endmodule
